// File: rtl/fft_reorder.sv
// ============================================================================
//  Module   : fft_reorder
//  Purpose  : Ping-pong reorder buffer after the last FFT stage; re-emits
//             each frame in natural order. Macro FFT_REORDER_BITREV_EN
//             enables bit-reversed write addressing (else a frame delay line).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_reorder #(
   parameter int DBW = 4,
   parameter int CBW = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [CBW-1:0]     cnt,
   input  logic [2*DBW-1:0]   din,
   output logic [2*DBW-1:0]   dout,
   output logic               dout_valid,
   output logic               dout_first
);

   localparam int             N      = 1 << CBW;
   localparam logic [CBW-1:0] C_LAST = CBW'(N - 1);
   localparam logic [CBW-1:0] C_ZERO = '0;

   typedef enum logic [1:0] {
      S_WAIT   = 2'd0,
      S_FILL   = 2'd1,
      S_STREAM = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic             r_wbank;
   logic             w_rbank;
   logic             w_wr_en;
   logic             w_rd_en;
   logic             w_toggle;
   logic [CBW-1:0]   w_waddr;
   logic [2*DBW-1:0] r_mem [2][N];

   assign w_rbank = ~r_wbank;

`ifdef FFT_REORDER_BITREV_EN
   for (genvar i = 0; i < CBW; i++) begin : g_bitrev
      assign w_waddr[i] = cnt[CBW-1-i];
   end
`else
   assign w_waddr = cnt;
`endif

   // Writes and bank toggles share the cnt==N-1 edge; the last write still
   // lands in the old bank because r_wbank is sampled before it flips.
   always_comb begin
      w_next_state = r_state;
      w_wr_en      = 1'b0;
      w_rd_en      = 1'b0;
      w_toggle     = 1'b0;
      case (r_state)
         S_WAIT: begin
            if (cnt == C_ZERO) begin
               w_wr_en      = 1'b1;
               w_next_state = S_FILL;
            end
         end
         S_FILL: begin
            w_wr_en = 1'b1;
            if (cnt == C_LAST) begin
               w_toggle     = 1'b1;
               w_next_state = S_STREAM;
            end
         end
         S_STREAM: begin
            w_wr_en = 1'b1;
            w_rd_en = 1'b1;
            if (cnt == C_LAST) begin
               w_toggle = 1'b1;
            end
         end
         default: begin
            w_next_state = S_WAIT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_WAIT;
         r_wbank <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_toggle) begin
            r_wbank <= ~r_wbank;
         end
      end
   end

   // Output register: dout holds its last value outside STREAM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         dout_first <= 1'b0;
      end else begin
         dout_valid <= w_rd_en;
         dout_first <= w_rd_en && (cnt == C_ZERO);
         if (w_rd_en) begin
            dout <= r_mem[w_rbank][cnt];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wbank][w_waddr] <= din;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fft_reorder.sv
// ============================================================================
//  Module   : tb_fft_reorder
//  Purpose  : Directed self-checking bench for fft_reorder (DBW=4, CBW=3).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fft_reorder;

   logic       clk;
   logic       rst;
   logic [2:0] cnt;
   logic [7:0] din;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_first;

   int n_checks = 0;
   int n_errors = 0;

   fft_reorder #(.DBW(4), .CBW(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .cnt        (cnt),
      .din        (din),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_first (dout_first)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Frame stimulus: 0 re=k im=0; 1 im=k+1; 2 im=-(k+1); 3 extremes; 4 partial-frame marker
   function automatic logic [7:0] din_of(input int mode, input int k);
      logic [3:0] re;
      logic [3:0] im;
      re = 4'(k);
      case (mode)
         0:       im = 4'h0;
         1:       im = 4'(k + 1);
         2:       im = 4'(-(k + 1));
         3:       return 8'h87;
         default: im = 4'h5;
      endcase
      return {im, re};
   endfunction

   // Input position whose sample appears as output bin j
   function automatic int src_pos(input int j);
      logic [2:0] jj;
      jj = 3'(j);
`ifdef FFT_REORDER_BITREV_EN
      return int'({jj[0], jj[1], jj[2]});
`else
      return int'(jj);
`endif
   endfunction

   task automatic cycle(input int c, input logic [7:0] d, input logic exp_v,
                        input logic exp_f, input logic [7:0] exp_d, input string tag);
      cnt = 3'(c);
      din = d;
      @(posedge clk);
      #1;
      check($sformatf("%s valid c%0d", tag, c), 32'(dout_valid), 32'(exp_v));
      check($sformatf("%s first c%0d", tag, c), 32'(dout_first), 32'(exp_f));
      check($sformatf("%s dout c%0d", tag, c), 32'(dout), 32'(exp_d));
   endtask

   task automatic run_frame(input int mode_in, input int mode_out, input logic exp_v, input string tag);
      for (int j = 0; j < 8; j++) begin
         cycle(j, din_of(mode_in, j), exp_v, exp_v && (j == 0),
               exp_v ? din_of(mode_out, src_pos(j)) : 8'h00, tag);
      end
   endtask

   initial begin
      rst = 1'b0;
      cnt = 3'd0;
      din = 8'h00;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset dout", 32'(dout), 32'h0);
      check("reset valid", 32'(dout_valid), 32'h0);
      check("reset first", 32'(dout_first), 32'h0);
      rst = 1'b0;

      run_frame(0, 0, 1'b0, "fill");
      run_frame(1, 0, 1'b1, "order");
      run_frame(2, 1, 1'b1, "frameA");
      run_frame(3, 2, 1'b1, "frameB");
      run_frame(0, 3, 1'b1, "extreme");

      // Reset in STREAM right after the cnt==5 edge
      for (int j = 0; j < 6; j++) begin
         cycle(j, din_of(0, j), 1'b1, j == 0, din_of(0, src_pos(j)), "prerst");
      end
      rst = 1'b1;
      #1;
      check("async rst dout", 32'(dout), 32'h0);
      check("async rst valid", 32'(dout_valid), 32'h0);
      check("async rst first", 32'(dout_first), 32'h0);
      cycle(6, din_of(0, 6), 1'b0, 1'b0, 8'h00, "inrst");
      cycle(7, din_of(0, 7), 1'b0, 1'b0, 8'h00, "inrst");
      for (int j = 0; j < 3; j++) begin
         cycle(j, din_of(0, j), 1'b0, 1'b0, 8'h00, "inrst");
      end
      rst = 1'b0;

      // Released so the first live edge sees cnt==3: those samples are dropped
      for (int j = 3; j < 8; j++) begin
         cycle(j, din_of(4, j), 1'b0, 1'b0, 8'h00, "wait");
      end
      run_frame(1, 0, 1'b0, "refill");
      run_frame(0, 1, 1'b1, "resume");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
